// File: rtl/cpu.sv
// UART boot-loaded 32-bit core. It loads a data image, a delimiter and an instruction
// image from UART_RX, then runs LSL/CMPS/PRINTC_R/EXIT and prints bytes on UART_TX.
module cpu #(
  parameter int T          = 130,
  parameter int IMEM_DEPTH = 1024,
  parameter int DMEM_DEPTH = 1024
) (
  input  logic       CLK,
  input  logic       INITIALIZE,
  input  logic       UART_RX,
  input  logic       START_EXEC,
  output logic       UART_TX,
  output logic [7:0] LED
);

  // Depths are powers of two, so pointer and PC overflow provides the modulo wrap.
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);
  localparam int CW  = $clog2(T + 1);

  localparam logic [CW-1:0] BIT_END   = CW'(T - 1);
  localparam logic [CW-1:0] HALF_END  = CW'(T / 2 - 1);
  localparam logic [31:0]   DELIM     = 32'hFFFF_FFFF;
  localparam logic [5:0]    OP_LSL    = 6'b010111;
  localparam logic [5:0]    OP_CMPS   = 6'b111001;
  localparam logic [5:0]    OP_PRINTC = 6'b101000;
  localparam logic [5:0]    OP_EXIT   = 6'b110010;

  typedef enum logic [2:0] {LOAD_DATA, LOAD_INST, RUN, TXWAIT, HALT} state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  state_t         state_r, state_s;
  rx_state_t      rx_state_r, rx_state_s;

  logic           rx_meta_r, rx_sync_r, rx_prev_r;
  logic [CW-1:0]  rx_cnt_r, rx_cnt_s;
  logic [2:0]     rx_bit_r, rx_bit_s;
  logic [7:0]     rx_shift_r, rx_shift_s;
  logic           rx_byte_s;

  logic [1:0]     byte_cnt_r;
  logic [23:0]    word_r;
  logic [31:0]    full_word_s;
  logic           loading_s, word_done_s, dmem_we_s, imem_we_s, start_run_s;
  logic [DAW-1:0] dptr_r;
  logic [IAW-1:0] iptr_r, pc_r;

  logic [31:0]    dmem_r [DMEM_DEPTH];
  logic [31:0]    imem_r [IMEM_DEPTH];
  logic [31:0]    regs_r [32];

  logic [31:0]    instr_s;
  logic [5:0]     opcode_s;
  logic [4:0]     rd_s, rs_s, rt_s;
  logic [2:0]     cond_s;
  logic [DAW-1:0] laddr_s;
  logic           cmp_s;
  logic           unused_s;

  logic           tx_r;
  logic [7:0]     led_r;
  logic [9:0]     tx_frame_r;
  logic [CW-1:0]  tx_cnt_r;
  logic [3:0]     tx_bit_r;
  logic           tx_last_s;

  assign instr_s     = imem_r[pc_r];
  assign opcode_s    = instr_s[31:26];
  assign rd_s        = instr_s[25:21];
  assign rs_s        = instr_s[20:16];
  assign rt_s        = instr_s[15:11];
  assign cond_s      = instr_s[10:8];
  assign laddr_s     = DAW'(instr_s[20:5] % 16'(DMEM_DEPTH));
  assign unused_s    = ^instr_s[4:0];

  assign loading_s   = (state_r == LOAD_DATA) || (state_r == LOAD_INST);
  assign full_word_s = {word_r, rx_shift_r};
  assign word_done_s = loading_s && rx_byte_s && (byte_cnt_r == 2'd3);
  assign tx_last_s   = (tx_cnt_r == BIT_END) && (tx_bit_r == 4'd9);

  assign UART_TX     = tx_r;
  assign LED         = led_r;

  // RX synchronizer and receiver state registers
  always_ff @(posedge CLK) begin
    if (INITIALIZE) begin
      rx_meta_r  <= 1'b1;
      rx_sync_r  <= 1'b1;
      rx_prev_r  <= 1'b1;
      rx_state_r <= RX_IDLE;
      rx_cnt_r   <= '0;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'd0;
    end else begin
      rx_meta_r  <= UART_RX;
      rx_sync_r  <= rx_meta_r;
      rx_prev_r  <= rx_sync_r;
      rx_state_r <= rx_state_s;
      rx_cnt_r   <= rx_cnt_s;
      rx_bit_r   <= rx_bit_s;
      rx_shift_r <= rx_shift_s;
    end
  end

  // 8N1 receiver: start re-checked at half bit, data and stop sampled mid-bit
  always_comb begin
    rx_state_s = rx_state_r;
    rx_cnt_s   = rx_cnt_r + CW'(1);
    rx_bit_s   = rx_bit_r;
    rx_shift_s = rx_shift_r;
    rx_byte_s  = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        rx_cnt_s = '0;
        if (rx_prev_r && !rx_sync_r) rx_state_s = RX_START;
        else rx_state_s = RX_IDLE;
      end
      RX_START: begin
        if (rx_cnt_r == HALF_END) begin
          rx_cnt_s = '0;
          rx_bit_s = 3'd0;
          if (rx_sync_r) rx_state_s = RX_IDLE;
          else rx_state_s = RX_DATA;
        end else begin
          rx_state_s = RX_START;
        end
      end
      RX_DATA: begin
        if (rx_cnt_r == BIT_END) begin
          rx_cnt_s   = '0;
          rx_shift_s = {rx_sync_r, rx_shift_r[7:1]};
          rx_bit_s   = rx_bit_r + 3'd1;
          if (rx_bit_r == 3'd7) rx_state_s = RX_STOP;
          else rx_state_s = RX_DATA;
        end else begin
          rx_state_s = RX_DATA;
        end
      end
      RX_STOP: begin
        if (rx_cnt_r == BIT_END) begin
          rx_byte_s  = rx_sync_r;
          rx_state_s = RX_IDLE;
        end else begin
          rx_state_s = RX_STOP;
        end
      end
      default: rx_state_s = RX_IDLE;
    endcase
  end

  // Signed compare selected by cond; the two reserved encodings yield 0
  always_comb begin
    cmp_s = 1'b0;
    case (cond_s)
      3'b000:  cmp_s = ($signed(regs_r[rs_s]) == $signed(regs_r[rt_s]));
      3'b001:  cmp_s = ($signed(regs_r[rs_s]) != $signed(regs_r[rt_s]));
      3'b100:  cmp_s = ($signed(regs_r[rs_s]) <  $signed(regs_r[rt_s]));
      3'b101:  cmp_s = ($signed(regs_r[rs_s]) <= $signed(regs_r[rt_s]));
      3'b110:  cmp_s = ($signed(regs_r[rs_s]) >  $signed(regs_r[rt_s]));
      3'b111:  cmp_s = ($signed(regs_r[rs_s]) >= $signed(regs_r[rt_s]));
      default: cmp_s = 1'b0;
    endcase
  end

  // Core state register
  always_ff @(posedge CLK) begin
    if (INITIALIZE) state_r <= LOAD_DATA;
    else state_r <= state_s;
  end

  // Next state and memory write strobes; START_EXEC wins over a completing word
  always_comb begin
    state_s     = state_r;
    dmem_we_s   = 1'b0;
    imem_we_s   = 1'b0;
    start_run_s = 1'b0;
    case (state_r)
      LOAD_DATA: begin
        if (START_EXEC) begin
          state_s     = RUN;
          start_run_s = 1'b1;
        end else if (word_done_s && (full_word_s == DELIM)) begin
          state_s = LOAD_INST;
        end else if (word_done_s) begin
          dmem_we_s = 1'b1;
        end else begin
          state_s = LOAD_DATA;
        end
      end
      LOAD_INST: begin
        if (START_EXEC) begin
          state_s     = RUN;
          start_run_s = 1'b1;
        end else if (word_done_s) begin
          imem_we_s = 1'b1;
        end else begin
          state_s = LOAD_INST;
        end
      end
      RUN: begin
        case (opcode_s)
          OP_PRINTC: state_s = TXWAIT;
          OP_EXIT:   state_s = HALT;
          default:   state_s = RUN;
        endcase
      end
      TXWAIT: begin
        if (tx_last_s) state_s = RUN;
        else state_s = TXWAIT;
      end
      HALT:    state_s = HALT;
      default: state_s = LOAD_DATA;
    endcase
  end

  // Memories keep their contents across INITIALIZE; only the pointers reset
  always_ff @(posedge CLK) begin
    if (dmem_we_s && !INITIALIZE) dmem_r[dptr_r] <= full_word_s;
    if (imem_we_s && !INITIALIZE) imem_r[iptr_r] <= full_word_s;
  end

  // Word assembly, pointers, execution datapath and UART transmitter
  always_ff @(posedge CLK) begin
    if (INITIALIZE) begin
      byte_cnt_r <= 2'd0;
      word_r     <= 24'd0;
      dptr_r     <= '0;
      iptr_r     <= '0;
      pc_r       <= '0;
      led_r      <= 8'd0;
      tx_r       <= 1'b1;
      tx_frame_r <= 10'h3FF;
      tx_cnt_r   <= '0;
      tx_bit_r   <= 4'd0;
      for (int i = 0; i < 32; i++) regs_r[i] <= 32'd0;
    end else begin
      if (start_run_s) begin
        byte_cnt_r <= 2'd0;
      end else if (loading_s && rx_byte_s) begin
        byte_cnt_r <= byte_cnt_r + 2'd1;
        word_r     <= {word_r[15:0], rx_shift_r};
      end
      if (dmem_we_s) dptr_r <= dptr_r + DAW'(1);
      if (imem_we_s) iptr_r <= iptr_r + IAW'(1);

      if (start_run_s) begin
        pc_r <= '0;
      end else if (state_r == RUN) begin
        case (opcode_s)
          OP_LSL: begin
            regs_r[rd_s] <= dmem_r[laddr_s];
            pc_r         <= pc_r + IAW'(1);
          end
          OP_CMPS: begin
            regs_r[rd_s] <= {31'd0, cmp_s};
            pc_r         <= pc_r + IAW'(1);
          end
          OP_PRINTC: begin
            led_r      <= regs_r[rd_s][7:0];
            tx_frame_r <= {1'b1, regs_r[rd_s][7:0], 1'b0};
            tx_r       <= 1'b0;
            tx_cnt_r   <= '0;
            tx_bit_r   <= 4'd0;
            pc_r       <= pc_r + IAW'(1);
          end
          OP_EXIT: pc_r <= pc_r;
          default: pc_r <= pc_r + IAW'(1);
        endcase
      end else if (state_r == TXWAIT) begin
        if (tx_cnt_r == BIT_END) begin
          tx_cnt_r <= '0;
          if (tx_bit_r == 4'd9) begin
            tx_r <= 1'b1;
          end else begin
            tx_bit_r <= tx_bit_r + 4'd1;
            tx_r     <= tx_frame_r[tx_bit_r + 4'd1];
          end
        end else begin
          tx_cnt_r <= tx_cnt_r + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu.sv
// Bench for cpu: boots programs over UART, predicts printed bytes with an
// instruction-level model and checks every received TX frame via a scoreboard.
module tb_cpu;
  localparam int T     = 16;
  localparam int DEPTH = 1024;

  logic       CLK        = 1'b0;
  logic       INITIALIZE = 1'b1;
  logic       UART_RX    = 1'b1;
  logic       START_EXEC = 1'b0;
  logic       UART_TX;
  logic [7:0] LED;

  int          checks      = 0;
  int          errors      = 0;
  int          frames_seen = 0;
  int          cyc         = 0;
  bit          abort_frame = 1'b0;
  logic [7:0]  exp_q[$];
  logic [31:0] dq[$];
  logic [31:0] iq[$];
  logic [31:0] dmem_m [DEPTH];
  logic [31:0] imem_m [DEPTH];
  logic [7:0]  led_m;

  cpu #(.T(T), .IMEM_DEPTH(DEPTH), .DMEM_DEPTH(DEPTH)) dut (
    .CLK(CLK), .INITIALIZE(INITIALIZE), .UART_RX(UART_RX),
    .START_EXEC(START_EXEC), .UART_TX(UART_TX), .LED(LED)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  function automatic logic [31:0] enc_lsl(input logic [4:0] rd, input logic [15:0] imm);
    logic [31:0] r;
    r = $urandom;
    return {6'b010111, rd, imm, r[4:0]};
  endfunction

  function automatic logic [31:0] enc_cmps(input logic [4:0] rd, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [2:0] cond);
    logic [31:0] r;
    r = $urandom;
    return {6'b111001, rd, rs, rt, cond, r[7:0]};
  endfunction

  function automatic logic [31:0] enc_printc(input logic [4:0] rs);
    return {6'b101000, rs, 21'd0};
  endfunction

  function automatic logic [31:0] enc_exit();
    return {6'b110010, 26'd0};
  endfunction

  function automatic logic [31:0] enc_nop();
    logic [31:0] r;
    logic [5:0]  op;
    op = 6'b010111;
    while (op == 6'b010111 || op == 6'b111001 || op == 6'b101000 || op == 6'b110010)
      op = 6'($urandom_range(0, 63));
    r = $urandom;
    return {op, r[25:0]};
  endfunction

  // Instruction-level reference: executes the image and predicts the printed bytes.
  task automatic run_model();
    logic [31:0] regs [32];
    logic [31:0] ins;
    int          pc, a, b, r;
    bit          done;
    pc = 0; done = 1'b0; led_m = 8'h00;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    for (int step = 0; step < 4 * DEPTH && !done; step++) begin
      ins = imem_m[pc];
      a = regs[ins[20:16]];
      b = regs[ins[15:11]];
      case (ins[31:26])
        6'b010111: regs[ins[25:21]] = dmem_m[ins[20:5] % DEPTH];
        6'b111001: begin
          case (ins[10:8])
            3'd0: r = (a == b) ? 1 : 0;
            3'd1: r = (a != b) ? 1 : 0;
            3'd4: r = (a <  b) ? 1 : 0;
            3'd5: r = (a <= b) ? 1 : 0;
            3'd6: r = (a >  b) ? 1 : 0;
            3'd7: r = (a >= b) ? 1 : 0;
            default: r = 0;
          endcase
          regs[ins[25:21]] = r;
        end
        6'b101000: begin
          exp_q.push_back(regs[ins[25:21]][7:0]);
          led_m = regs[ins[25:21]][7:0];
        end
        6'b110010: done = 1'b1;
        default: ;
      endcase
      if (!done) pc = (pc + 1) % DEPTH;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    UART_RX = 1'b0;
    tick(T);
    for (int k = 0; k < 8; k++) begin
      UART_RX = b[k];
      tick(T);
    end
    UART_RX = 1'b1;
    tick(T + 4);
  endtask

  task automatic send_word(input logic [31:0] w, input bit glitch);
    for (int k = 3; k >= 0; k--) begin
      send_byte(w[8*k +: 8]);
      if (glitch && k == 3) begin
        UART_RX = 1'b0;
        tick(2);
        UART_RX = 1'b1;
        tick(T + 4);
      end
    end
  endtask

  task automatic do_init();
    INITIALIZE  = 1'b1;
    START_EXEC  = 1'b0;
    UART_RX     = 1'b1;
    abort_frame = 1'b1;
    exp_q.delete();
    tick(1);
    check("reset_uart_tx", UART_TX, 1);
    check("reset_led", LED, 0);
    INITIALIZE = 1'b0;
    tick(2);
  endtask

  task automatic load_prog(input bit glitch);
    do_init();
    for (int i = 0; i < dq.size(); i++) begin
      dmem_m[i] = dq[i];
      send_word(dq[i], glitch && i == 0);
    end
    send_word(32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < iq.size(); i++) begin
      imem_m[i] = iq[i];
      send_word(iq[i], 1'b0);
    end
  endtask

  task automatic start_prog();
    run_model();
    START_EXEC = 1'b1;
    tick(2);
    START_EXEC = 1'b0;
  endtask

  task automatic wait_drain();
    int bound, waited;
    bound = (exp_q.size() + 1) * 12 * T + 200;
    waited = 0;
    while (exp_q.size() != 0 && waited < bound) begin
      tick(1);
      waited++;
    end
    check("tx_pending_after_run", exp_q.size(), 0);
    tick(4);
    check("led_after_run", LED, led_m);
    check("tx_idle_after_halt", UART_TX, 1);
  endtask

  task automatic gen_random();
    int nd, ni, np;
    logic [31:0] v;
    dq.delete(); iq.delete();
    nd = $urandom_range(1, 4);
    for (int i = 0; i < nd; i++) begin
      case ($urandom_range(0, 3))
        0: v = 32'h8000_0000;
        1: v = 32'h7FFF_FFFF;
        2: v = $urandom_range(0, 255);
        default: v = $urandom;
      endcase
      if (v == 32'hFFFF_FFFF) v = 32'hFFFF_FFFE;
      dq.push_back(v);
    end
    ni = $urandom_range(3, 8);
    np = 0;
    for (int i = 0; i < ni; i++) begin
      case ($urandom_range(0, 3))
        0: iq.push_back(enc_lsl(5'($urandom_range(0, 7)),
                                16'($urandom_range(0, nd - 1) + 1024 * $urandom_range(0, 63))));
        1: iq.push_back(enc_cmps(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                 5'($urandom_range(0, 7)), 3'($urandom_range(0, 7))));
        2: begin
          if (np < 2) begin
            iq.push_back(enc_printc(5'($urandom_range(0, 7))));
            np++;
          end else begin
            iq.push_back(enc_nop());
          end
        end
        default: iq.push_back(enc_nop());
      endcase
    end
    iq.push_back(enc_printc(5'($urandom_range(0, 7))));
    iq.push_back(enc_exit());
  endtask

  task automatic read_frame(output bit aborted, output logic [7:0] b);
    aborted = 1'b0;
    b = 8'h00;
    repeat (T / 2) @(negedge CLK);
    if (abort_frame) begin aborted = 1'b1; return; end
    check("tx_start_bit", UART_TX, 0);
    for (int k = 0; k < 8; k++) begin
      repeat (T) @(negedge CLK);
      if (abort_frame) begin aborted = 1'b1; return; end
      b[k] = UART_TX;
    end
    repeat (T) @(negedge CLK);
    if (abort_frame) begin aborted = 1'b1; return; end
    check("tx_stop_bit", UART_TX, 1);
    repeat (T / 2 - 1) @(negedge CLK);
    if (abort_frame) begin aborted = 1'b1; return; end
    check("tx_stop_bit_end", UART_TX, 1);
  endtask

  // Monitor: decodes every frame on UART_TX and scores it against the queue.
  initial begin : monitor
    logic       tx_prev;
    logic [7:0] b;
    bit         aborted, have_prev;
    int         start_cyc, last_start;
    tx_prev = 1'b1; have_prev = 1'b0; last_start = 0;
    forever begin
      @(negedge CLK);
      if (abort_frame) begin
        abort_frame = 1'b0;
        have_prev   = 1'b0;
      end else if (tx_prev === 1'b1 && UART_TX === 1'b0) begin
        start_cyc = cyc;
        read_frame(aborted, b);
        if (aborted) begin
          abort_frame = 1'b0;
          have_prev   = 1'b0;
        end else begin
          frames_seen++;
          if (have_prev) begin
            checks++;
            if (start_cyc - last_start < 10 * T) begin
              errors++;
              $display("FAIL frame_spacing: got %0d cycles required >= %0d", start_cyc - last_start, 10 * T);
            end
          end
          have_prev  = 1'b1;
          last_start = start_cyc;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got byte %h required no frame", b);
          end else begin
            check("tx_byte", b, exp_q.pop_front());
          end
        end
      end
      tx_prev = UART_TX;
    end
  end

  initial begin : stimulus
    int snap, waited;
    tick(3);

    // Both LSLs write r0 (rd field is 0), r1 stays 0; the model works out the compare.
    dq.delete(); iq.delete();
    dq.push_back(32'hFFFF_FFFC); dq.push_back(32'hFFFF_FFFE);
    iq.push_back(32'h5C00_0000); iq.push_back(32'h5C00_0020); iq.push_back(32'hE440_0C00);
    iq.push_back(32'hA040_0000); iq.push_back(32'hC800_0000);
    load_prog(1'b0); start_prog(); wait_drain();

    snap = frames_seen;
    START_EXEC = 1'b1; tick(2); START_EXEC = 1'b0;
    tick(12 * T);
    check("frames_after_exit", frames_seen, snap);
    check("led_after_exit", LED, led_m);

    dq.delete();
    dq.push_back(32'hFFFF_FFFE); dq.push_back(32'hFFFF_FFFC);
    load_prog(1'b0); start_prog(); wait_drain();

    load_prog(1'b1); start_prog(); wait_drain();

    dq.delete(); iq.delete();
    dq.push_back(32'h0000_0041); dq.push_back(32'h0000_0041);
    iq.push_back(enc_lsl(5'd3, 16'd0)); iq.push_back(enc_lsl(5'd4, 16'd1));
    iq.push_back(enc_cmps(5'd5, 5'd3, 5'd4, 3'd0));
    iq.push_back(enc_printc(5'd5)); iq.push_back(enc_printc(5'd5)); iq.push_back(enc_exit());
    load_prog(1'b0); start_prog(); wait_drain();

    // INITIALIZE while a frame is on the line; imm 1024 wraps to dmem[0].
    dq.delete(); iq.delete();
    dq.push_back(32'h0000_0080);
    iq.push_back(enc_lsl(5'd1, 16'd1024)); iq.push_back(enc_printc(5'd1)); iq.push_back(enc_exit());
    load_prog(1'b0); start_prog();
    waited = 0;
    while (UART_TX !== 1'b0 && waited < 200) begin
      tick(1);
      waited++;
    end
    check("tx_frame_started", UART_TX, 0);
    tick(3 * T);
    do_init();

    for (int n = 0; n < 3; n++) begin
      gen_random();
      load_prog(1'b0); start_prog(); wait_drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
